// File: rtl/systolic_output_collector_pkg.sv
// Shared types and helpers for the systolic output collector.
// The COLLECTOR_ACCUM_EN macro (accumulate mode) is handled in the interface and top files.
package systolic_collect_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Flat position of element (r,c) inside result_matrix, in words.
  function automatic int elem_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction

  // One spare bit so a counter can hold the value ROWS itself.
  function automatic int row_cnt_width(input int rows);
    return $clog2(rows) + 1;
  endfunction

endpackage

// File: rtl/systolic_output_collector_if.sv
// Handshake/data bundle between the systolic array, the collector and its consumer.
// COLLECTOR_ACCUM_EN adds the acc_clear input.
interface systolic_output_collector_if #(
  parameter int WORD_SIZE = 16,
  parameter int ROWS      = 4,
  parameter int COLS      = 4
);
  logic                           arm;
  logic [COLS*WORD_SIZE-1:0]      bottom_out;
  logic [COLS-1:0]                output_col_valid;
  logic [ROWS*COLS*WORD_SIZE-1:0] result_matrix;
  logic                           result_valid;
  logic                           result_ack;
  logic                           busy;
  logic [COLS-1:0]                cols_done;
  logic                           overflow_err;
  logic                           timeout_err;
`ifdef COLLECTOR_ACCUM_EN
  logic                           acc_clear;

  modport master (
    output arm, bottom_out, output_col_valid, result_ack, acc_clear,
    input  result_matrix, result_valid, busy, cols_done, overflow_err, timeout_err
  );
  modport slave (
    input  arm, bottom_out, output_col_valid, result_ack, acc_clear,
    output result_matrix, result_valid, busy, cols_done, overflow_err, timeout_err
  );
`else
  modport master (
    output arm, bottom_out, output_col_valid, result_ack,
    input  result_matrix, result_valid, busy, cols_done, overflow_err, timeout_err
  );
  modport slave (
    input  arm, bottom_out, output_col_valid, result_ack,
    output result_matrix, result_valid, busy, cols_done, overflow_err, timeout_err
  );
`endif
endinterface

// File: rtl/systolic_output_collector_column.sv
// Per-column row counter: decides where each arriving word lands and flags
// completion and overflow for one column of the result matrix.
module collector_column
  import systolic_collect_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int CW   = row_cnt_width(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_collect,
  input  logic          i_done_state,
  input  logic          i_valid,
  output logic          o_wr_en,
  output logic [CW-1:0] o_row,
  output logic          o_overflow,
  output logic          o_done,
  output logic          o_done_next
);
  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

  logic [CW-1:0] r_row_cnt;
  logic          r_done;
  logic          w_full;

  assign w_full      = (r_row_cnt == ROWS_C);
  assign o_wr_en     = i_collect && !i_clear && i_valid && !w_full;
  // A restart swallows anything arriving on the same edge.
  assign o_overflow  = !i_clear && i_valid && ((i_collect && w_full) || i_done_state);
  assign o_done_next = w_full || (o_wr_en && (r_row_cnt == ROWS_C - CW'(1)));
  assign o_row       = r_row_cnt;
  assign o_done      = r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row_cnt <= '0;
      r_done    <= 1'b0;
    end else if (i_clear) begin
      r_row_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      if (o_wr_en)
        r_row_cnt <= r_row_cnt + CW'(1);
      if (i_collect)
        r_done <= o_done_next;
    end
  end

endmodule

// File: rtl/systolic_output_collector.sv
// Collects the skewed systolic bottom outputs into a ROWS x COLS matrix and hands it
// downstream with valid/ack. Define COLLECTOR_ACCUM_EN to accumulate instead of overwrite.
module systolic_output_collector
  import systolic_collect_pkg::*;
#(
  parameter int WORD_SIZE      = 16,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                         clk,
  input logic                         rst,
  systolic_output_collector_if.slave  bus
);
  localparam int CW = row_cnt_width(ROWS);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t                         r_state;
  state_t                         w_state_next;
  logic [TW-1:0]                  r_cyc;
  logic                           r_overflow;
  logic                           r_timeout;
  logic [ROWS*COLS*WORD_SIZE-1:0] r_matrix;

  logic            w_collect;
  logic            w_in_done;
  logic            w_arm_go;
  logic            w_all_done;
  logic            w_timeout_hit;
  logic [COLS-1:0] w_wr_en;
  logic [COLS-1:0] w_ovf;
  logic [COLS-1:0] w_done;
  logic [COLS-1:0] w_done_next;
  logic [CW-1:0]   w_row [COLS];

  assign w_collect     = (r_state == COLLECT);
  assign w_in_done     = (r_state == DONE);
  // In DONE an arm only counts when the current result is being accepted.
  assign w_arm_go      = bus.arm && (!w_in_done || bus.result_ack);
  assign w_all_done    = &w_done_next;
  assign w_timeout_hit = w_collect && (r_cyc == TO_LAST);

  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
      collector_column #(.ROWS(ROWS)) u_col (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_arm_go),
        .i_collect   (w_collect),
        .i_done_state(w_in_done),
        .i_valid     (bus.output_col_valid[gi]),
        .o_wr_en     (w_wr_en[gi]),
        .o_row       (w_row[gi]),
        .o_overflow  (w_ovf[gi]),
        .o_done      (w_done[gi]),
        .o_done_next (w_done_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  // Restart beats completion, and completion beats timeout.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_arm_go)
          w_state_next = COLLECT;
      end
      COLLECT: begin
        if (w_arm_go)
          w_state_next = COLLECT;
        else if (w_all_done)
          w_state_next = DONE;
        else if (w_timeout_hit)
          w_state_next = IDLE;
      end
      DONE: begin
        if (bus.result_ack)
          w_state_next = w_arm_go ? COLLECT : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy         = 1'b0;
    bus.result_valid = 1'b0;
    case (r_state)
      COLLECT: bus.busy         = 1'b1;
      DONE:    bus.result_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc      <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_arm_go) begin
      r_cyc      <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_collect)
        r_cyc <= r_cyc + TW'(1);
      if (|w_ovf)
        r_overflow <= 1'b1;
      if (w_timeout_hit && !w_all_done)
        r_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_matrix <= '0;
    end
`ifdef COLLECTOR_ACCUM_EN
    else if (bus.acc_clear && !w_collect) begin
      r_matrix <= '0;
    end
`endif
    else begin
      for (int c = 0; c < COLS; c++) begin
        for (int r = 0; r < ROWS; r++) begin
          if (w_wr_en[c] && (w_row[c] == CW'(r))) begin
`ifdef COLLECTOR_ACCUM_EN
            r_matrix[elem_idx(r, c, COLS)*WORD_SIZE +: WORD_SIZE] <=
              r_matrix[elem_idx(r, c, COLS)*WORD_SIZE +: WORD_SIZE] +
              bus.bottom_out[c*WORD_SIZE +: WORD_SIZE];
`else
            r_matrix[elem_idx(r, c, COLS)*WORD_SIZE +: WORD_SIZE] <=
              bus.bottom_out[c*WORD_SIZE +: WORD_SIZE];
`endif
          end
        end
      end
    end
  end

  assign bus.result_matrix = r_matrix;
  assign bus.cols_done     = w_done;
  assign bus.overflow_err  = r_overflow;
  assign bus.timeout_err   = r_timeout;

endmodule

// File: tb/tb_systolic_output_collector.sv
// Directed bench for systolic_output_collector at 2x2; adapts expectations when
// COLLECTOR_ACCUM_EN is defined.
module tb_systolic_output_collector;
  localparam int W  = 16;
  localparam int R  = 2;
  localparam int C  = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_output_collector_if #(.WORD_SIZE(W), .ROWS(R), .COLS(C)) sif();

  systolic_output_collector #(
    .WORD_SIZE(W), .ROWS(R), .COLS(C), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        arm;
    logic [1:0]  v;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        ack;
    logic        rv;
    logic        busy;
    logic        ovf;
    logic [1:0]  cd;
    logic [63:0] mat;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [63:0] m(input logic [15:0] e00, input logic [15:0] e01,
                                    input logic [15:0] e10, input logic [15:0] e11);
    return {e11, e10, e01, e00};
  endfunction

  function automatic vec_t mk(input logic a, input logic [1:0] v, input logic [15:0] d0,
                              input logic [15:0] d1, input logic ack, input logic rv,
                              input logic busy, input logic ovf, input logic [1:0] cd,
                              input logic [63:0] mat);
    vec_t t;
    t.arm = a; t.v = v; t.d0 = d0; t.d1 = d1; t.ack = ack;
    t.rv = rv; t.busy = busy; t.ovf = ovf; t.cd = cd; t.mat = mat;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic a, input logic [1:0] v, input logic [15:0] d0,
                      input logic [15:0] d1, input logic ack);
    @(negedge clk);
    sif.arm              = a;
    sif.output_col_valid = v;
    sif.bottom_out       = {d1, d0};
    sif.result_ack       = ack;
`ifdef COLLECTOR_ACCUM_EN
    sif.acc_clear        = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    sif.arm = 1'b0; sif.output_col_valid = '0; sif.bottom_out = '0; sif.result_ack = 1'b0;
`ifdef COLLECTOR_ACCUM_EN
    sif.acc_clear = 1'b0;
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // 2x2 stream: (0,0)=a,(1,0)=b,(0,1)=c,(1,1)=d with the column-1 skew.
  task automatic stream(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] c, input logic [15:0] d);
    step(1'b0, 2'b01, a, 16'd0, 1'b0);
    step(1'b0, 2'b11, b, c, 1'b0);
    step(1'b0, 2'b10, 16'd0, d, 1'b0);
  endtask

  initial begin
    logic [63:0] m_a;
    logic [63:0] m_b;
    logic [63:0] m_c;
    logic        rv_seen;

    rst = 1'b1;
    sif.arm = 1'b0; sif.output_col_valid = '0; sif.bottom_out = '0; sif.result_ack = 1'b0;
`ifdef COLLECTOR_ACCUM_EN
    sif.acc_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_result_valid", 64'(sif.result_valid), 64'd0);
    check("reset_busy",         64'(sif.busy),         64'd0);
    check("reset_cols_done",    64'(sif.cols_done),    64'd0);
    check("reset_overflow",     64'(sif.overflow_err), 64'd0);
    check("reset_timeout",      64'(sif.timeout_err),  64'd0);
    check("reset_matrix",       sif.result_matrix,     64'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef COLLECTOR_ACCUM_EN
    m_a = m(16'd6,  16'd9,  16'd6,  16'd8);
    m_b = m(16'd6,  16'd9,  16'd9,  16'd12);
    m_c = m(16'd15, 16'd19, 16'd9,  16'd12);
`else
    m_a = m(16'd1,  16'd2,  16'd6,  16'd8);
    m_b = m(16'd1,  16'd2,  16'd3,  16'd4);
    m_c = m(16'd9,  16'd10, 16'd3,  16'd4);
`endif

    tbl[0]  = mk(1, 2'b00, 0,  0,  0, 0, 1, 0, 2'b00, 64'd0);
    tbl[1]  = mk(0, 2'b01, 5,  0,  0, 0, 1, 0, 2'b00, m(5, 0, 0, 0));
    tbl[2]  = mk(0, 2'b11, 6,  7,  0, 0, 1, 0, 2'b01, m(5, 7, 6, 0));
    tbl[3]  = mk(0, 2'b10, 0,  8,  0, 1, 0, 0, 2'b11, m(5, 7, 6, 8));
    tbl[4]  = mk(0, 2'b11, 99, 99, 0, 1, 0, 1, 2'b11, m(5, 7, 6, 8));
    tbl[5]  = mk(0, 2'b00, 0,  0,  1, 0, 0, 1, 2'b11, m(5, 7, 6, 8));
    tbl[6]  = mk(0, 2'b11, 42, 42, 0, 0, 0, 1, 2'b11, m(5, 7, 6, 8));
    tbl[7]  = mk(1, 2'b00, 0,  0,  0, 0, 1, 0, 2'b00, m(5, 7, 6, 8));
    tbl[8]  = mk(0, 2'b11, 1,  2,  0, 0, 1, 0, 2'b00, m_a);
    tbl[9]  = mk(0, 2'b11, 3,  4,  0, 1, 0, 0, 2'b11, m_b);
    tbl[10] = mk(1, 2'b00, 0,  0,  1, 0, 1, 0, 2'b00, m_b);
    tbl[11] = mk(0, 2'b11, 9,  10, 0, 0, 1, 0, 2'b00, m_c);
`ifdef COLLECTOR_ACCUM_EN
    tbl[12] = mk(0, 2'b11, 11, 12, 0, 1, 0, 0, 2'b11, m(16'd15, 16'd19, 16'd20, 16'd24));
    tbl[13] = mk(1, 2'b00, 0,  0,  0, 1, 0, 0, 2'b11, m(16'd15, 16'd19, 16'd20, 16'd24));
    tbl[14] = mk(0, 2'b00, 0,  0,  1, 0, 0, 0, 2'b11, m(16'd15, 16'd19, 16'd20, 16'd24));
`else
    tbl[12] = mk(0, 2'b11, 11, 12, 0, 1, 0, 0, 2'b11, m(16'd9, 16'd10, 16'd11, 16'd12));
    tbl[13] = mk(1, 2'b00, 0,  0,  0, 1, 0, 0, 2'b11, m(16'd9, 16'd10, 16'd11, 16'd12));
    tbl[14] = mk(0, 2'b00, 0,  0,  1, 0, 0, 0, 2'b11, m(16'd9, 16'd10, 16'd11, 16'd12));
`endif

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].arm, tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].ack);
      $display("vec %0d arm=%0b valid=%b ack=%0b -> rv=%0b busy=%0b ovf=%0b cd=%b mat=%h",
               i, tbl[i].arm, tbl[i].v, tbl[i].ack, sif.result_valid, sif.busy,
               sif.overflow_err, sif.cols_done, sif.result_matrix);
      check($sformatf("vec%0d_result_valid", i), 64'(sif.result_valid), 64'(tbl[i].rv));
      check($sformatf("vec%0d_busy", i),         64'(sif.busy),         64'(tbl[i].busy));
      check($sformatf("vec%0d_overflow", i),     64'(sif.overflow_err), 64'(tbl[i].ovf));
      check($sformatf("vec%0d_cols_done", i),    64'(sif.cols_done),    64'(tbl[i].cd));
      check($sformatf("vec%0d_matrix", i),       sif.result_matrix,     tbl[i].mat);
    end

    // Reset in the middle of a collection discards the partial matrix.
    reset_dut();
    step(1'b1, 2'b00, 0, 0, 1'b0);
    step(1'b0, 2'b01, 16'd5, 0, 1'b0);
    check("midrst_partial", sif.result_matrix, m(5, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    sif.output_col_valid = '0;
    @(posedge clk);
    #1;
    $display("midrst busy=%0b rv=%0b mat=%h", sif.busy, sif.result_valid, sif.result_matrix);
    check("midrst_matrix",    sif.result_matrix,     64'd0);
    check("midrst_busy",      64'(sif.busy),         64'd0);
    check("midrst_cols_done", 64'(sif.cols_done),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 2'b00, 0, 0, 1'b0);
    stream(16'd5, 16'd6, 16'd7, 16'd8);
    $display("after midrst rv=%0b mat=%h", sif.result_valid, sif.result_matrix);
    check("midrst_redo_valid",    64'(sif.result_valid), 64'd1);
    check("midrst_redo_matrix",   sif.result_matrix,     m(5, 7, 6, 8));
    check("midrst_redo_overflow", 64'(sif.overflow_err), 64'd0);

    // Timeout: 63 empty cycles keep collecting, the 64th aborts.
    reset_dut();
    step(1'b1, 2'b00, 0, 0, 1'b0);
    rv_seen = 1'b0;
    for (int k = 1; k < TO; k++) begin
      step(1'b0, 2'b00, 0, 0, 1'b0);
      rv_seen = rv_seen | sif.result_valid;
    end
    check("timeout_busy_at63",  64'(sif.busy),        64'd1);
    check("timeout_err_at63",   64'(sif.timeout_err), 64'd0);
    step(1'b0, 2'b00, 0, 0, 1'b0);
    rv_seen = rv_seen | sif.result_valid;
    $display("timeout busy=%0b timeout_err=%0b rv_seen=%0b", sif.busy, sif.timeout_err, rv_seen);
    check("timeout_err_at64",  64'(sif.timeout_err), 64'd1);
    check("timeout_busy_at64", 64'(sif.busy),        64'd0);
    check("timeout_rv_never",  64'(rv_seen),         64'd0);

    // Completion landing on the timeout edge wins.
    reset_dut();
    step(1'b1, 2'b00, 0, 0, 1'b0);
    for (int k = 1; k < TO - 1; k++)
      step(1'b0, 2'b00, 0, 0, 1'b0);
    step(1'b0, 2'b11, 16'd1, 16'd2, 1'b0);
    step(1'b0, 2'b11, 16'd3, 16'd4, 1'b0);
    $display("race rv=%0b timeout_err=%0b mat=%h", sif.result_valid, sif.timeout_err,
             sif.result_matrix);
    check("race_result_valid", 64'(sif.result_valid), 64'd1);
    check("race_timeout_err",  64'(sif.timeout_err),  64'd0);
    check("race_matrix",       sif.result_matrix,     m(1, 2, 3, 4));

`ifdef COLLECTOR_ACCUM_EN
    // Two tiles accumulate, then acc_clear in DONE wipes the matrix.
    reset_dut();
    step(1'b1, 2'b00, 0, 0, 1'b0);
    stream(16'd5, 16'd6, 16'd7, 16'd8);
    step(1'b1, 2'b00, 0, 0, 1'b1);
    stream(16'd5, 16'd6, 16'd7, 16'd8);
    $display("accum rv=%0b mat=%h", sif.result_valid, sif.result_matrix);
    check("accum_valid",  64'(sif.result_valid), 64'd1);
    check("accum_matrix", sif.result_matrix,     m(10, 14, 12, 16));
    @(negedge clk);
    sif.acc_clear = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    sif.acc_clear = 1'b0;
    $display("acc_clear mat=%h", sif.result_matrix);
    check("accum_clear_matrix", sif.result_matrix, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
